grid_ctrl: RTL

GRID_CTRL -- requirements
Module: grid_ctrl

---
 rtl/grid_pkg.sv | 48 ++++
 rtl/grid_cursor.sv | 70 +++++++
 rtl/grid_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// Shared grid types and constants: 4x4 cell grid, 12-bit RGB palette, command and FSM enums.
// Build option GRID_WRAP_EN (see grid_cursor) changes edge behaviour only; nothing here depends on it.
package grid_pkg;

  localparam int GRID_N    = 4;
  localparam int CELL_BITS = 12;
  localparam int ROW_BITS  = GRID_N * CELL_BITS;

  localparam logic [CELL_BITS-1:0] PAL_BLACK = 12'h000;
  localparam logic [CELL_BITS-1:0] PAL_RED   = 12'hF00;
  localparam logic [CELL_BITS-1:0] PAL_GREEN = 12'h0F0;
  localparam logic [CELL_BITS-1:0] PAL_BLUE  = 12'h00F;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4,
    SEL   = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } state_e;

  function automatic logic [1:0] oh2idx(input logic [GRID_N-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < GRID_N; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Colours outside the palette fall back to the start of the cycle.
  function automatic logic [CELL_BITS-1:0] pal_next(input logic [CELL_BITS-1:0] c);
    case (c)
      PAL_BLACK: return PAL_RED;
      PAL_RED:   return PAL_GREEN;
      PAL_GREEN: return PAL_BLUE;
      default:   return PAL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/grid_cursor.sv
// One-hot row/col cursor; moves on mv_vld in one cycle, reject is combinational for the same cycle.
// GRID_WRAP_EN defined: edges wrap and never reject; undefined: edge moves hold and assert reject.
module grid_cursor
  import grid_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mv_vld,
  input  cmd_e              mv_cmd,
  output logic [GRID_N-1:0] row,
  output logic [GRID_N-1:0] col,
  output logic              reject
);

  logic [GRID_N-1:0] row_q;
  logic [GRID_N-1:0] col_q;
  logic              at_edge;

  always_comb begin
    at_edge = 1'b0;
    case (mv_cmd)
      UP:      at_edge = row_q[0];
      DOWN:    at_edge = row_q[GRID_N-1];
      LEFT:    at_edge = col_q[0];
      RIGHT:   at_edge = col_q[GRID_N-1];
      default: at_edge = 1'b0;
    endcase
  end

`ifdef GRID_WRAP_EN
  assign reject = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= 4'b0001;
      col_q <= 4'b0001;
    end else if (mv_vld) begin
      case (mv_cmd)
        UP:      row_q <= {row_q[0], row_q[GRID_N-1:1]};
        DOWN:    row_q <= {row_q[GRID_N-2:0], row_q[GRID_N-1]};
        LEFT:    col_q <= {col_q[0], col_q[GRID_N-1:1]};
        RIGHT:   col_q <= {col_q[GRID_N-2:0], col_q[GRID_N-1]};
        default: ;
      endcase
    end
  end
`else
  assign reject = mv_vld && at_edge;

  // Edge moves are blocked here, so a plain shift can never drop the hot bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= 4'b0001;
      col_q <= 4'b0001;
    end else if (mv_vld && !at_edge) begin
      case (mv_cmd)
        UP:      row_q <= row_q >> 1;
        DOWN:    row_q <= row_q << 1;
        LEFT:    col_q <= col_q >> 1;
        RIGHT:   col_q <= col_q << 1;
        default: ;
      endcase
    end
  end
`endif

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/grid_ctrl.sv
// Grid cursor/colour controller: one command latched per idle period, committed the cycle after frame_start.
// Latency: outputs change on the 2nd edge counting the frame_start sample; commands arriving while busy are dropped. Option: GRID_WRAP_EN.
module grid_ctrl
  import grid_pkg::*;
#(
  parameter int ERR_FRAMES = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_sel,
  input  logic                frame_start,
  output logic [GRID_N-1:0]   row,
  output logic [GRID_N-1:0]   col,
  output logic [ROW_BITS-1:0] x1,
  output logic [ROW_BITS-1:0] x2,
  output logic [ROW_BITS-1:0] x3,
  output logic [ROW_BITS-1:0] x4,
  output logic                error
);

  state_e                           state_q;
  cmd_e                             cmd_q;
  cmd_e                             btn_cmd;
  logic [GRID_N-1:0][ROW_BITS-1:0]  grid_q;
  logic [5:0]                       err_cnt_q;
  logic [5:0]                       err_cnt_nxt;
  logic                             error_q;
  logic                             mv_vld;
  logic                             reject;
  logic [1:0]                       cur_r;
  logic [1:0]                       cur_c;

  always_comb begin
    btn_cmd = NONE;
    if (btn_sel)        btn_cmd = SEL;
    else if (btn_up)    btn_cmd = UP;
    else if (btn_down)  btn_cmd = DOWN;
    else if (btn_left)  btn_cmd = LEFT;
    else if (btn_right) btn_cmd = RIGHT;
  end

  assign mv_vld = (state_q == APPLY) && (cmd_q != NONE) && (cmd_q != SEL);

  grid_cursor u_cursor (
    .clk    (clk),
    .rst_n  (rst_n),
    .mv_vld (mv_vld),
    .mv_cmd (cmd_q),
    .row    (row),
    .col    (col),
    .reject (reject)
  );

  assign cur_r = oh2idx(row);
  assign cur_c = oh2idx(col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= NONE;
      grid_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_cmd != NONE) begin
            cmd_q   <= btn_cmd;
            state_q <= PEND;
          end
        end
        PEND: begin
          if (frame_start) state_q <= APPLY;
        end
        APPLY: begin
          if (cmd_q == SEL) begin
            grid_q[cur_r][int'(cur_c)*CELL_BITS +: CELL_BITS] <=
              pal_next(grid_q[cur_r][int'(cur_c)*CELL_BITS +: CELL_BITS]);
          end
          cmd_q   <= NONE;
          state_q <= IDLE;
        end
        default: begin
          cmd_q   <= NONE;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A reject reloads to the full count rather than adding to what is left.
  always_comb begin
    err_cnt_nxt = err_cnt_q;
    if (reject)
      err_cnt_nxt = 6'(ERR_FRAMES);
    else if (frame_start && (err_cnt_q != '0))
      err_cnt_nxt = err_cnt_q - 6'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      error_q   <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_nxt;
      error_q   <= (err_cnt_nxt != '0);
    end
  end

  assign x1    = grid_q[0];
  assign x2    = grid_q[1];
  assign x3    = grid_q[2];
  assign x4    = grid_q[3];
  assign error = error_q;

endmodule
